// File: rtl/gpio_pwm_ctrl_if.sv
// gpio_pwm_ctrl_if: CPU data-store bus into the GPIO/PWM register block.
interface gpio_pwm_ctrl_if;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  modport master (output we, addr, wr_data, input rd_data);
  modport slave (input we, addr, wr_data, output rd_data);
endinterface

// File: rtl/gpio_pwm_ctrl.sv
// gpio_pwm_ctrl: memory-mapped GPIO/LED controller with direct, PWM, blink and inverted modes per channel.
module gpio_pwm_ctrl #(
  parameter int          NUM_CH     = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h20000,
  parameter int          PRESCALE_W = 16,
  parameter int          PWM_W      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  gpio_pwm_ctrl_if.slave      bus,
  output logic [NUM_CH-1:0]   gpio_o
);
  localparam logic [PWM_W-1:0] PWM_MAX = '1;
  logic [NUM_CH-1:0]     out_r;
  logic [2*NUM_CH-1:0]   mode_r;
  logic [PRESCALE_W-1:0] presc_r;
  logic [PRESCALE_W-1:0] tick_cnt;
  logic [PWM_W-1:0]      pwm_cnt;
  logic [PWM_W-1:0]      duty [NUM_CH];
  logic [PWM_W-1:0]      duty_sh [NUM_CH];
  logic                  blink_ph;
  logic                  hit, wr, tick, wrap;
  logic [5:0]            off;
  logic [31:0]           rd_val;
  logic [NUM_CH-1:0]     gpio_nxt;
  logic                  unused_bits;
  assign hit         = bus.addr[31:8] == BASE_ADDR[31:8];
  assign off         = bus.addr[7:2];
  assign wr          = bus.we & hit;
  assign tick        = tick_cnt == presc_r;
  assign wrap        = tick & (pwm_cnt == PWM_MAX);
  assign unused_bits = ^{bus.addr[1:0], bus.wr_data};
  always_comb begin
    rd_val = !hit ? '0 :
             off == 6'd0 ? 32'(out_r) :
             off == 6'd1 ? 32'(mode_r) :
             off == 6'd2 ? 32'(presc_r) :
             off == 6'd3 ? {16'b0, 8'(pwm_cnt), 7'b0, blink_ph} : '0;
    for (int i = 0; i < NUM_CH; i++)
      if (hit && off == 6'(i + 4)) rd_val = 32'(duty[i]);
  end
  // mode bits {hi,lo}: 00 direct, 01 pwm, 10 blink, 11 inverted
  always_comb begin
    gpio_nxt = '0;
    for (int i = 0; i < NUM_CH; i++)
      gpio_nxt[i] = mode_r[2*i+1] ? (mode_r[2*i] ? ~out_r[i] : out_r[i] & blink_ph)
                                  : (mode_r[2*i] ? pwm_cnt < duty_sh[i] : out_r[i]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r       <= '0;
      mode_r      <= '0;
      presc_r     <= '0;
      tick_cnt    <= '0;
      pwm_cnt     <= '0;
      blink_ph    <= 1'b0;
      gpio_o      <= '0;
      bus.rd_data <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty[i]    <= '0;
        duty_sh[i] <= '0;
      end
    end else begin
      bus.rd_data <= rd_val;
      gpio_o      <= gpio_nxt;
      tick_cnt    <= ((wr && off == 6'd2) || tick) ? '0 : tick_cnt + PRESCALE_W'(1);
      if (tick) pwm_cnt <= pwm_cnt + PWM_W'(1);
      if (wrap) blink_ph <= ~blink_ph;
      if (wr && off == 6'd0) out_r <= bus.wr_data[NUM_CH-1:0];
      if (wr && off == 6'd1) mode_r <= bus.wr_data[2*NUM_CH-1:0];
      if (wr && off == 6'd2) presc_r <= bus.wr_data[PRESCALE_W-1:0];
      // shadow only reloads at period wrap so a duty change never cuts a pulse short
      for (int i = 0; i < NUM_CH; i++) begin
        if (wrap) duty_sh[i] <= duty[i];
        if (wr && off == 6'(i + 4)) duty[i] <= bus.wr_data[PWM_W-1:0];
      end
    end
  end
endmodule
